// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the parametrised UART transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Serial bits in one frame: start + payload + optional parity + stop bits.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Synchronous FIFO with wrap-bit pointers for the UART input queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_param.sv
// ============================================================================
//  Module      : uart_tx_param
//  Description : Parametrised UART transmitter with valid/ready host side.
//                Define UART_TX_FIFO_EN to place an input FIFO ahead of the engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CW         = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
    localparam int BW         = $clog2(FRAME_BITS);

    localparam logic [CW-1:0] CNT_LAST      = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_PRE       = CW'(CLK_DIV - 2);
    localparam logic [BW-1:0] IDX_LAST_DATA = BW'(DATA_BITS);
    localparam logic [BW-1:0] IDX_LAST      = BW'(FRAME_BITS - 1);

    // FIFO_DEPTH is validated in every build so a configuration stays legal when the FIFO is enabled.
    if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_param: illegal parameter combination");
    end

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 w_bit_end;
    logic                 w_last_bit;
    logic                 w_eng_ready;
    logic                 w_src_valid;
    logic [DATA_BITS-1:0] w_src_data;
    logic                 w_take;

    assign w_bit_end   = (r_cnt == CNT_LAST);
    assign w_last_bit  = (r_bit_idx == IDX_LAST);
    assign w_eng_ready = (r_state == ST_IDLE) || (r_state == ST_STOP && w_last_bit && w_bit_end);
    assign w_take      = w_src_valid && w_eng_ready;

`ifdef UART_TX_FIFO_EN
    logic w_fifo_full;
    logic w_fifo_empty;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid && !w_fifo_full),
        .din   (tx_data),
        .pop   (w_take),
        .dout  (w_src_data),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_src_valid = !w_fifo_empty;
    assign tx_ready    = !w_fifo_full;
`else
    assign w_src_valid = tx_valid;
    assign w_src_data  = tx_data;
    assign tx_ready    = w_eng_ready;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_take) begin
                r_state   <= ST_START;
                r_cnt     <= '0;
                r_bit_idx <= '0;
                r_shift   <= w_src_data;
                r_par     <= (PARITY == PAR_ODD) ? ~^w_src_data : ^w_src_data;
                tx        <= 1'b0;
                busy      <= 1'b1;
            end else if (r_state != ST_IDLE) begin
                r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
                // Raised one cycle early so the registered pulse lands on the final bit_end.
                if (r_state == ST_STOP && w_last_bit && r_cnt == CNT_PRE) begin
                    frame_done <= 1'b1;
                end
                if (w_bit_end) begin
                    r_bit_idx <= r_bit_idx + 1'b1;
                    case (r_state)
                        ST_START: begin
                            r_state <= ST_DATA;
                            tx      <= r_shift[0];
                        end
                        ST_DATA: begin
                            r_shift <= r_shift >> 1;
                            if (r_bit_idx == IDX_LAST_DATA) begin
                                if (PARITY != PAR_NONE) begin
                                    r_state <= ST_PARITY;
                                    tx      <= r_par;
                                end else begin
                                    r_state <= ST_STOP;
                                    tx      <= 1'b1;
                                end
                            end else begin
                                tx <= r_shift[1];
                            end
                        end
                        ST_PARITY: begin
                            r_state <= ST_STOP;
                            tx      <= 1'b1;
                        end
                        ST_STOP: begin
                            if (w_last_bit) begin
                                r_state <= ST_IDLE;
                                busy    <= 1'b0;
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_param.sv
// ============================================================================
//  Module      : tb_uart_tx_param
//  Description : Scoreboard bench for uart_tx_param across four frame formats.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic [3:0] vld;
    logic [1:0] sel;
    wire  [3:0] rdy;
    wire  [3:0] txo;
    wire  [3:0] bsy;
    wire  [3:0] fd;

    int chk = 0;
    int err = 0;
    int cyc = 0;

    string exp_q[$];
    bit    gap_q[$];
    bit    mon_en   = 1'b0;
    bit    mon_busy = 1'b0;
    int    end_cyc  = 0;

    wire m_tx  = txo[sel];
    wire m_fd  = fd[sel];
    wire m_rdy = rdy[sel];
    wire m_bsy = bsy[sel];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2; all at 4 clocks per bit
    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .tx_data(din), .tx_valid(vld[0]), .tx_ready(rdy[0]),
        .tx(txo[0]), .busy(bsy[0]), .frame_done(fd[0]));
    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .tx_data(din), .tx_valid(vld[1]), .tx_ready(rdy[1]),
        .tx(txo[1]), .busy(bsy[1]), .frame_done(fd[1]));
    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .rst(rst), .tx_data(din), .tx_valid(vld[2]), .tx_ready(rdy[2]),
        .tx(txo[2]), .busy(bsy[2]), .frame_done(fd[2]));
    uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
        .clk(clk), .rst(rst), .tx_data(din[6:0]), .tx_valid(vld[3]), .tx_ready(rdy[3]),
        .tx(txo[3]), .busy(bsy[3]), .frame_done(fd[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: on each start bit pop the expected bit string and check every cycle of the frame.
    initial begin
        string e;
        bit    g;
        int    n;
        int    w;
        bit    last;
        forever begin
            @(negedge clk);
            if (mon_en && m_tx == 1'b0) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    w = 0;
                    while (m_tx == 1'b0 && w < 200) begin
                        @(negedge clk);
                        w++;
                    end
                end else begin
                    e = exp_q.pop_front();
                    g = gap_q.pop_front();
                    if (g) check("gapless_start", cyc - end_cyc, 1);
                    n = e.len();
                    for (int b = 0; b < n; b++) begin
                        for (int c = 0; c < 4; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            last = (b == n - 1) && (c == 3);
                            check("tx_bit", m_tx, (e[b] == "1") ? 1 : 0);
                            check("frame_done", m_fd, last);
                            check("busy", m_bsy, 1);
`ifndef UART_TX_FIFO_EN
                            check("tx_ready", m_rdy, last);
`endif
                        end
                    end
                    end_cyc = cyc;
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic send(input int k, input logic [7:0] d, input string e, input bit gap, input bit track);
        int n;
        n = 0;
        @(negedge clk);
        din    = d;
        vld[k] = 1'b1;
        if (track) begin
            exp_q.push_back(e);
            gap_q.push_back(gap);
        end
        while (!rdy[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("handshake", rdy[k], 1);
        @(posedge clk);
`ifndef UART_TX_FIFO_EN
        @(negedge clk);
        check("start_latency", txo[k], 0);
`endif
    endtask

    task automatic drop();
        @(negedge clk);
        vld = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || mon_busy || bsy != 4'h0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain", (n < 2000) ? 1 : 0, 1);
    endtask

    initial begin
        int start_c;
        int n;
        int lows;
        int pulses;
        rst = 1'b1;
        vld = '0;
        din = '0;
        sel = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", txo, 4'hF);
        check("reset_ready", rdy, 4'hF);
        check("reset_busy", bsy, 4'h0);
        check("reset_frame_done", fd, 4'h0);
        rst    = 1'b0;
        mon_en = 1'b1;

        sel = 2'd0;
        send(0, 8'hA5, "0101001011", 1'b0, 1'b1); drop(); wait_idle();
        send(0, 8'h00, "0000000001", 1'b0, 1'b1); drop(); wait_idle();
        send(0, 8'hFF, "0111111111", 1'b0, 1'b1); drop(); wait_idle();
        send(0, 8'h55, "0101010101", 1'b0, 1'b1);
        send(0, 8'h0F, "0111100001", 1'b1, 1'b1); drop(); wait_idle();

        sel = 2'd1;
        send(1, 8'hA5, "01010010101", 1'b0, 1'b1); drop(); wait_idle();
        send(1, 8'h01, "01000000011", 1'b0, 1'b1); drop(); wait_idle();

        sel = 2'd2;
        send(2, 8'hA5, "01010010111", 1'b0, 1'b1); drop(); wait_idle();
        send(2, 8'h01, "01000000001", 1'b0, 1'b1); drop(); wait_idle();

        sel = 2'd3;
        send(3, 8'h7F, "0111111111", 1'b0, 1'b1); drop(); wait_idle();
        send(3, 8'h2A, "0010101011", 1'b0, 1'b1); drop(); wait_idle();

        // Abort a frame with reset on its 13th cycle.
        sel    = 2'd0;
        mon_en = 1'b0;
        send(0, 8'hC3, "", 1'b0, 1'b0);
        drop();
        n = 0;
        while (m_tx != 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_frame_started", m_tx, 0);
        start_c = cyc;
        while (cyc < start_c + 12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx", m_tx, 1);
        check("abort_ready", m_rdy, 1);
        check("abort_busy", m_bsy, 0);
        lows   = 0;
        pulses = 0;
        for (int i = 0; i < 48; i++) begin
            if (m_tx == 1'b0) lows++;
            if (m_fd == 1'b1) pulses++;
            @(negedge clk);
        end
        check("abort_line_idle", lows, 0);
        check("abort_no_frame_done", pulses, 0);
        mon_en = 1'b1;
        send(0, 8'hA5, "0101001011", 1'b0, 1'b1); drop(); wait_idle();

`ifdef UART_TX_FIFO_EN
        send(0, 8'h11, "0100010001", 1'b0, 1'b1);
        send(0, 8'h22, "0010001001", 1'b1, 1'b1);
        send(0, 8'h33, "0110011001", 1'b1, 1'b1);
        send(0, 8'h44, "0001000101", 1'b1, 1'b1);
        send(0, 8'h55, "0101010101", 1'b1, 1'b1);
        @(negedge clk);
        check("fifo_full_ready", rdy[0], 0);
        vld = '0;
        wait_idle();
`endif

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
